// File: rtl/mfp_board_io_pkg.sv
// Shared constants and helpers for the board I/O front end.
// Holds the default channel count, the debounce and heartbeat intervals, and the
// function that sizes an interval counter.
package mfp_board_io_pkg;

    localparam int unsigned N_IN_DEFAULT      = 6;
    localparam int unsigned DB_CYCLES_DEFAULT = 500000;   // 10 ms at 50 MHz
    localparam int unsigned HB_CYCLES_DEFAULT = 25000000; // 0.5 s at 50 MHz

    // Width of a counter sized as $clog2(cycles), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/mfp_debounce_channel.sv
// One debounced board input channel.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   raw_in - asynchronous, bouncing input (1 = active)
//   db_out - debounced level
//   rise   - one-cycle pulse after a debounced 0->1 update
//   fall   - one-cycle pulse after a debounced 1->0 update
// The input passes a two-flop synchronizer; the synchronized value must differ
// from db_out for DB_CYCLES consecutive cycles before db_out follows it.
module mfp_debounce_channel
    import mfp_board_io_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic db_out,
    output logic rise,
    output logic fall
);

    localparam int unsigned   CW       = cnt_width(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where s2 agrees with db restarts the interval; the counter is
    // cleared on the load cycle so it never wraps.
    always_comb begin
        cnt_d  = '0;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d   = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= raw_in;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_out = db_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/mfp_board_io_frontend.sv
// Board I/O front end: N_IN debounced switch/button channels plus a registered
// LED source mux selected by debounced channel SEL_CH.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   raw_in[N_IN]        - raw board inputs (1 = active)
//   led_src_a/b[N_LED]  - LED sources for select = 0 / 1
//   db_out, rise, fall  - per-channel debounced level and edge pulses
//   led[N_LED]          - registered LED drive
// Optional feature: define MFP_BOARD_IO_HEARTBEAT_EN to drive led[N_LED-1] from
// a heartbeat bit toggling every HB_CYCLES cycles instead of from the mux.
module mfp_board_io_frontend
    import mfp_board_io_pkg::*;
#(
    parameter int unsigned N_IN      = N_IN_DEFAULT,
    parameter int unsigned N_LED     = 8,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int unsigned SEL_CH    = 3,
    parameter int unsigned HB_CYCLES = HB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  raw_in,
    input  logic [N_LED-1:0] led_src_a,
    input  logic [N_LED-1:0] led_src_b,
    output logic [N_IN-1:0]  db_out,
    output logic [N_IN-1:0]  rise,
    output logic [N_IN-1:0]  fall,
    output logic [N_LED-1:0] led
);

    for (genvar i = 0; i < int'(N_IN); i++) begin : g_ch
        mfp_debounce_channel #(
            .DB_CYCLES (DB_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw_in (raw_in[i]),
            .db_out (db_out[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

`ifdef MFP_BOARD_IO_HEARTBEAT_EN
    localparam int unsigned   HW      = cnt_width(HB_CYCLES);
    localparam logic [HW-1:0] HB_LAST = HW'(HB_CYCLES - 1);

    logic [HW-1:0] hb_cnt_q, hb_cnt_d;
    logic          hb_q, hb_d;

    always_comb begin
        hb_cnt_d = hb_cnt_q + HW'(1);
        hb_d     = hb_q;
        if (hb_cnt_q == HB_LAST) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end
`endif

    logic [N_LED-1:0] led_q, led_d;

    always_comb begin
        led_d = db_out[SEL_CH] ? led_src_b : led_src_a;
`ifdef MFP_BOARD_IO_HEARTBEAT_EN
        // Registered copy of the heartbeat, so led[N_LED-1] tracks hb_q exactly.
        led_d[N_LED-1] = hb_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_mfp_board_io_frontend.sv
// Self-checking bench for mfp_board_io_frontend (DB_CYCLES=4, HB_CYCLES=3).
// Directed scenarios use spec-derived constants; the random scenario uses a
// sliding-window reference model over the recorded input history.
module tb_mfp_board_io_frontend;

    localparam int N_IN  = 6;
    localparam int N_LED = 8;
    localparam int DB    = 4;
    localparam int SEL   = 3;
    localparam int HB    = 3;
    localparam int MAXE  = 4096;
`ifdef MFP_BOARD_IO_HEARTBEAT_EN
    localparam logic [7:0] LED_MASK = 8'h7F;
`else
    localparam logic [7:0] LED_MASK = 8'hFF;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N_IN-1:0]  raw_in;
    logic [N_LED-1:0] led_src_a;
    logic [N_LED-1:0] led_src_b;
    logic [N_IN-1:0]  db_out;
    logic [N_IN-1:0]  rise;
    logic [N_IN-1:0]  fall;
    logic [N_LED-1:0] led;

    int n_checks = 0;
    int n_pass   = 0;

    mfp_board_io_frontend #(
        .N_IN      (N_IN),
        .N_LED     (N_LED),
        .DB_CYCLES (DB),
        .SEL_CH    (SEL),
        .HB_CYCLES (HB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .led_src_a (led_src_a),
        .led_src_b (led_src_b),
        .db_out    (db_out),
        .rise      (rise),
        .fall      (fall),
        .led       (led)
    );

    always #5 clk = ~clk;

    // Reference model: per-edge history of synchronizer input (0 under reset).
    logic [N_IN-1:0] eff_h [MAXE];
    bit              rst_h [MAXE];
    int              ec = 0;
    logic [N_IN-1:0] m_db, m_rise, m_fall;
    logic [7:0]      m_led;

    // Advance one rising edge, update the model, return 1 time unit later.
    task automatic step();
        bit stable;
        logic sv;
        @(posedge clk);
        if (ec >= MAXE) begin
            $display("FAIL history_overflow edges=%0d limit=%0d", ec, MAXE);
            $fatal(1);
        end
        rst_h[ec] = rst;
        eff_h[ec] = rst ? '0 : raw_in;
        if (rst) begin
            m_db = '0; m_rise = '0; m_fall = '0; m_led = '0;
        end else begin
            m_led  = m_db[SEL] ? led_src_b : led_src_a;
            m_rise = '0;
            m_fall = '0;
            // db flips when the synchronized input differed from it on each of
            // the last DB non-reset edges.
            for (int ch = 0; ch < N_IN; ch++) begin
                stable = 1'b1;
                for (int j = ec - DB + 1; j <= ec; j++) begin
                    if (j < 0 || rst_h[j]) stable = 1'b0;
                    else begin
                        sv = (j - 2 < 0) ? 1'b0 : eff_h[j-2][ch];
                        if (sv == m_db[ch]) stable = 1'b0;
                    end
                end
                if (stable) begin
                    m_db[ch] = ~m_db[ch];
                    if (m_db[ch]) m_rise[ch] = 1'b1;
                    else          m_fall[ch] = 1'b1;
                end
            end
        end
        ec++;
        #1;
    endtask

    task automatic do_reset(input logic [N_IN-1:0] raw);
        rst = 1'b1;
        raw_in = raw;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw_in = 6'h3F;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++; if (db_out !== 6'h00) $display("FAIL reset_db got=%h exp=00", db_out); else n_pass++;
            n_checks++; if (rise !== 6'h00) $display("FAIL reset_rise got=%h exp=00", rise); else n_pass++;
            n_checks++; if (fall !== 6'h00) $display("FAIL reset_fall got=%h exp=00", fall); else n_pass++;
            n_checks++; if (led !== 8'h00) $display("FAIL reset_led got=%h exp=00", led); else n_pass++;
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++;
            if (rise !== ((k == 6) ? 6'h3F : 6'h00))
                $display("FAIL reset_release_rise edge=%0d got=%h exp=%h", k, rise,
                         (k == 6) ? 6'h3F : 6'h00);
            else n_pass++;
            n_checks++;
            if (fall !== 6'h00) $display("FAIL reset_release_fall edge=%0d got=%h exp=00", k, fall);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        do_reset(6'h00);
        step();
        raw_in = 6'h01;
        for (int k = 1; k <= 9; k++) begin
            step();
            n_checks++;
            if (db_out[0] !== (k >= 6)) $display("FAIL single_db edge=%0d got=%b exp=%b", k, db_out[0], k >= 6);
            else n_pass++;
            n_checks++;
            if (rise !== ((k == 6) ? 6'h01 : 6'h00))
                $display("FAIL single_rise edge=%0d got=%h exp=%h", k, rise, (k == 6) ? 6'h01 : 6'h00);
            else n_pass++;
            n_checks++;
            if (fall !== 6'h00) $display("FAIL single_fall edge=%0d got=%h exp=00", k, fall);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        do_reset(6'h00);
        step();
        raw_in = 6'h02;
        for (int k = 1; k <= 14; k++) begin
            if (k == 4) raw_in = 6'h00;
            step();
            n_checks++;
            if ({db_out[1], rise[1], fall[1]} !== 3'b000)
                $display("FAIL glitch edge=%0d got db/rise/fall=%b%b%b exp=000", k, db_out[1], rise[1], fall[1]);
            else n_pass++;
        end
    endtask

    task automatic test_simul();
        do_reset(6'h04);
        for (int k = 0; k < 8; k++) step();
        n_checks++;
        if (db_out !== 6'h04) $display("FAIL simul_setup got=%h exp=04", db_out); else n_pass++;
        raw_in = 6'h10;
        for (int k = 1; k <= 7; k++) begin
            step();
            n_checks++;
            if (fall !== ((k == 6) ? 6'h04 : 6'h00))
                $display("FAIL simul_fall edge=%0d got=%h exp=%h", k, fall, (k == 6) ? 6'h04 : 6'h00);
            else n_pass++;
            n_checks++;
            if (rise !== ((k == 6) ? 6'h10 : 6'h00))
                $display("FAIL simul_rise edge=%0d got=%h exp=%h", k, rise, (k == 6) ? 6'h10 : 6'h00);
            else n_pass++;
        end
    endtask

    task automatic test_led();
        logic [7:0] exp;
        led_src_a = 8'h55;
        led_src_b = 8'hAA;
        do_reset(6'h00);
        step();
        step();
        raw_in = 6'h08;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp = (k >= 7) ? 8'hAA : 8'h55;
            n_checks++;
            if ((led & LED_MASK) !== (exp & LED_MASK))
                $display("FAIL led_select edge=%0d got=%h exp=%h", k, led & LED_MASK, exp & LED_MASK);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset(6'h00);
        step();
        raw_in = 6'h01;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({rise, fall, db_out} !== 18'h0) $display("FAIL mid_reset_pulse got=%h exp=0", {rise, fall, db_out});
        else n_pass++;
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            n_checks++;
            if (rise !== ((k == 6) ? 6'h01 : 6'h00))
                $display("FAIL mid_reset_rise edge=%0d got=%h exp=%h", k, rise, (k == 6) ? 6'h01 : 6'h00);
            else n_pass++;
        end
    endtask

`ifdef MFP_BOARD_IO_HEARTBEAT_EN
    task automatic test_heartbeat();
        do_reset(6'h00);
        for (int k = 1; k <= 12; k++) begin
            step();
            n_checks++;
            if (led[7] !== 1'(((k / HB) % 2)))
                $display("FAIL heartbeat edge=%0d got=%b exp=%0d", k, led[7], (k / HB) % 2);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random();
        do_reset(6'h00);
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 5) == 0) raw_in = 6'($urandom);
            rst       = ($urandom_range(0, 99) == 0);
            led_src_a = 8'($urandom);
            led_src_b = 8'($urandom);
            step();
            n_checks++;
            if (db_out !== m_db) $display("FAIL rand_db cyc=%0d got=%h exp=%h", k, db_out, m_db); else n_pass++;
            n_checks++;
            if (rise !== m_rise) $display("FAIL rand_rise cyc=%0d got=%h exp=%h", k, rise, m_rise); else n_pass++;
            n_checks++;
            if (fall !== m_fall) $display("FAIL rand_fall cyc=%0d got=%h exp=%h", k, fall, m_fall); else n_pass++;
            n_checks++;
            if ((led & LED_MASK) !== (m_led & LED_MASK))
                $display("FAIL rand_led cyc=%0d got=%h exp=%h", k, led & LED_MASK, m_led & LED_MASK);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        raw_in    = '0;
        led_src_a = '0;
        led_src_b = '0;
        m_db = '0; m_rise = '0; m_fall = '0; m_led = '0;
        test_reset();
        test_single();
        test_glitch();
        test_simul();
        test_led();
        test_reset_mid();
`ifdef MFP_BOARD_IO_HEARTBEAT_EN
        test_heartbeat();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
